// File: rtl/config_pkg.sv
// Shared configuration for the privilege/trap sequencer: default sizing, mode encodings,
// the WFI state type and the illegal-instruction cause code.
// No ports; imported by trap_deleg and privmode_trap_seq.
package config_pkg;

  localparam int XLEN             = 64;
  localparam int S_SUPPORTED      = 1;
  localparam int U_SUPPORTED      = 1;
  localparam int WFI_TIMEOUT_BITS = 8;

  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

  typedef enum logic [1:0] {
    WFI_IDLE   = 2'd0,
    WFI_WAIT   = 2'd1,
    WFI_TOTRAP = 2'd2
  } wfi_state_t;

  // Map a requested privilege mode onto one the core actually implements.
  // The reserved encoding 2'b10 and any missing mode resolve to M.
  function automatic logic [1:0] coerce_mode(input logic [1:0] mode,
                                             input bit        s_ok,
                                             input bit        u_ok);
    logic [1:0] m;
    m = mode;
    if (mode == U_MODE && !u_ok) m = M_MODE;
    else if (mode == S_MODE && !s_ok) m = M_MODE;
    else if (mode == 2'b10) m = M_MODE;
    return m;
  endfunction

endpackage

// File: rtl/trap_deleg.sv
// Trap delegation decision: picks S or M as the trap target mode. Purely combinational,
// zero latency, no flow control.
// Ports: code/is_int (trap cause), medeleg/mideleg (delegation CSRs), priv (current mode) -> target.
module trap_deleg #(
  parameter int S_SUPPORTED = 1
) (
  input  logic [3:0]  code,
  input  logic        is_int,
  input  logic [15:0] medeleg,
  input  logic [11:0] mideleg,
  input  logic [1:0]  priv,
  output logic [1:0]  target
);
  import config_pkg::*;

  logic [15:0] med_eff;
  logic [15:0] mid_eff;
  logic        deleg_bit;

  // Environment-call-from-M (11) can never be delegated, nor can the machine-level
  // interrupts (11/7/3); those bits behave as hardwired zero.
  assign med_eff   = medeleg & ~16'h0800;
  assign mid_eff   = {4'b0000, mideleg & ~12'h888};
  assign deleg_bit = is_int ? mid_eff[code] : med_eff[code];

  // Traps taken from M never drop to S, regardless of delegation.
  assign target = ((S_SUPPORTED != 0) && (priv != M_MODE) && deleg_bit) ? S_MODE : M_MODE;

endmodule

// File: rtl/privmode_trap_seq.sv
// Privilege-mode owner and trap sequencer: selects one of interrupt / exception /
// illegal-instruction / mret / sret / wfi per cycle, computes the next privilege mode and
// cause, and runs the WFI wait/timeout FSM. Decisions are combinational (same cycle);
// PrivilegeModeW and the FSM update one cycle later and hold while StallW=1.
// Ports: clk/reset_n, StallW, trap sources (Exc*/Int*/IntWakeM), delegation CSRs,
// xret/wfi issue strobes, STATUS_* fields in; TrapM/mretM/sretM/NextPrivilegeModeM/
// PrivilegeModeW/CauseM/WFIStallM out.
module privmode_trap_seq #(
  parameter int XLEN             = config_pkg::XLEN,
  parameter int S_SUPPORTED      = config_pkg::S_SUPPORTED,
  parameter int U_SUPPORTED      = config_pkg::U_SUPPORTED,
  parameter int WFI_TIMEOUT_BITS = config_pkg::WFI_TIMEOUT_BITS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallW,
  input  logic            ExcValidM,
  input  logic [3:0]      ExcCodeM,
  input  logic            IntValidM,
  input  logic [3:0]      IntCodeM,
  input  logic            IntWakeM,
  input  logic [15:0]     MEDELEG_REGW,
  input  logic [11:0]     MIDELEG_REGW,
  input  logic            mretIssueM,
  input  logic            sretIssueM,
  input  logic            wfiIssueM,
  input  logic [1:0]      STATUS_MPP,
  input  logic            STATUS_SPP,
  input  logic            STATUS_TSR,
  input  logic            STATUS_TW,
  output logic            TrapM,
  output logic            mretM,
  output logic            sretM,
  output logic [1:0]      NextPrivilegeModeM,
  output logic [1:0]      PrivilegeModeW,
  output logic [XLEN-1:0] CauseM,
  output logic            WFIStallM
);
  import config_pkg::*;

  localparam int                    CW      = WFI_TIMEOUT_BITS;
  localparam logic [CW-1:0]         CNT_MAX = '1;
  localparam bit                    S_OK    = (S_SUPPORTED != 0);
  localparam bit                    U_OK    = (U_SUPPORTED != 0);

  wfi_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    priv_q;

  logic idle_st, wait_st, totrap_st;
  logic mret_illegal, sret_illegal, wfi_illegal, illegal_hit;
  logic take_int, take_exc, take_ill, retire_ok;
  logic take_mret, take_sret, take_wfi;
  logic timeout;
  logic [3:0] trap_code;
  logic [1:0] trap_target;

  trap_deleg #(.S_SUPPORTED(S_SUPPORTED)) u_deleg (
    .code    (trap_code),
    .is_int  (take_int),
    .medeleg (MEDELEG_REGW),
    .mideleg (MIDELEG_REGW),
    .priv    (priv_q),
    .target  (trap_target)
  );

  always_comb begin
    idle_st   = (state_q == WFI_IDLE);
    wait_st   = (state_q == WFI_WAIT);
    totrap_st = (state_q == WFI_TOTRAP);

    mret_illegal = mretIssueM && (priv_q != M_MODE);
    sret_illegal = sretIssueM && (!S_OK || (priv_q == U_MODE) ||
                                  ((priv_q == S_MODE) && STATUS_TSR));
    wfi_illegal  = wfiIssueM && (priv_q == U_MODE);
    illegal_hit  = mret_illegal || sret_illegal || wfi_illegal;

    // Interrupts are honoured in every FSM state; the instruction-side sources are only
    // looked at in IDLE because the instruction stream is frozen during WAIT/TOTRAP.
    take_int  = reset_n && IntValidM;
    take_exc  = reset_n && idle_st && !IntValidM && ExcValidM;
    take_ill  = reset_n && !IntValidM &&
                ((idle_st && !ExcValidM && illegal_hit) || totrap_st);
    retire_ok = reset_n && idle_st && !IntValidM && !ExcValidM && !illegal_hit;
    take_mret = retire_ok && mretIssueM;
    take_sret = retire_ok && !mretIssueM && sretIssueM;
    take_wfi  = retire_ok && !mretIssueM && !sretIssueM && wfiIssueM;

    TrapM = take_int || take_exc || take_ill;
    mretM = take_mret;
    sretM = take_sret;

    trap_code = take_int ? IntCodeM : (take_exc ? ExcCodeM : EXC_ILLEGAL_INSTR);
    CauseM    = '0;
    if (TrapM) CauseM = {take_int, {(XLEN-5){1'b0}}, trap_code};

    NextPrivilegeModeM = priv_q;
    if (TrapM)          NextPrivilegeModeM = trap_target;
    else if (take_mret) NextPrivilegeModeM = coerce_mode(STATUS_MPP, S_OK, U_OK);
    else if (take_sret) NextPrivilegeModeM = coerce_mode({1'b0, STATUS_SPP}, S_OK, U_OK);

    WFIStallM = reset_n && wait_st && !IntWakeM && !IntValidM;

    // The timeout compares the post-increment count, i.e. the number of WAIT cycles
    // spent including this one, so the stall lasts exactly 2^N-1 cycles before TOTRAP.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    timeout = STATUS_TW && (priv_q != M_MODE) && (cnt_inc == CNT_MAX);

    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      WFI_IDLE: begin
        if (take_wfi) state_d = WFI_WAIT;
      end
      WFI_WAIT: begin
        cnt_d = cnt_inc;
        if (IntValidM || IntWakeM) state_d = WFI_IDLE;
        else if (timeout)          state_d = WFI_TOTRAP;
      end
      WFI_TOTRAP: state_d = WFI_IDLE;
      default:    state_d = WFI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      priv_q  <= M_MODE;
      state_q <= WFI_IDLE;
      cnt_q   <= '0;
    end else if (!StallW) begin
      priv_q  <= NextPrivilegeModeM;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PrivilegeModeW = priv_q;

endmodule

// File: tb/tb_privmode_trap_seq.sv
// Directed bench for privmode_trap_seq: each step drives inputs, pushes the expected
// outputs to a scoreboard queue, and the queue head is compared at the following negedge.
// No ports.
module tb_privmode_trap_seq;
  localparam int XLEN = 64;
  localparam int NB   = 3;
  localparam logic [1:0] MM = 2'b11;
  localparam logic [1:0] SM = 2'b01;
  localparam logic [1:0] UM = 2'b00;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            StallW;
  logic            ExcValidM;
  logic [3:0]      ExcCodeM;
  logic            IntValidM;
  logic [3:0]      IntCodeM;
  logic            IntWakeM;
  logic [15:0]     MEDELEG_REGW;
  logic [11:0]     MIDELEG_REGW;
  logic            mretIssueM, sretIssueM, wfiIssueM;
  logic [1:0]      STATUS_MPP;
  logic            STATUS_SPP, STATUS_TSR, STATUS_TW;
  logic            TrapM, mretM, sretM;
  logic [1:0]      NextPrivilegeModeM, PrivilegeModeW;
  logic [XLEN-1:0] CauseM;
  logic            WFIStallM;

  always #5 clk = ~clk;

  privmode_trap_seq #(
    .XLEN(XLEN), .S_SUPPORTED(1), .U_SUPPORTED(1), .WFI_TIMEOUT_BITS(NB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .StallW(StallW),
    .ExcValidM(ExcValidM), .ExcCodeM(ExcCodeM),
    .IntValidM(IntValidM), .IntCodeM(IntCodeM), .IntWakeM(IntWakeM),
    .MEDELEG_REGW(MEDELEG_REGW), .MIDELEG_REGW(MIDELEG_REGW),
    .mretIssueM(mretIssueM), .sretIssueM(sretIssueM), .wfiIssueM(wfiIssueM),
    .STATUS_MPP(STATUS_MPP), .STATUS_SPP(STATUS_SPP),
    .STATUS_TSR(STATUS_TSR), .STATUS_TW(STATUS_TW),
    .TrapM(TrapM), .mretM(mretM), .sretM(sretM),
    .NextPrivilegeModeM(NextPrivilegeModeM), .PrivilegeModeW(PrivilegeModeW),
    .CauseM(CauseM), .WFIStallM(WFIStallM)
  );

  typedef struct {
    logic            trap;
    logic            mret;
    logic            sret;
    logic [1:0]      npriv;
    logic [1:0]      priv;
    logic [XLEN-1:0] cause;
    logic            stall;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  function automatic logic [XLEN-1:0] icause(input logic [3:0] c);
    return {1'b1, {(XLEN-5){1'b0}}, c};
  endfunction

  function automatic logic [XLEN-1:0] ecause(input logic [3:0] c);
    return {{(XLEN-4){1'b0}}, c};
  endfunction

  task automatic clr();
    StallW = 0; ExcValidM = 0; ExcCodeM = 0; IntValidM = 0; IntCodeM = 0; IntWakeM = 0;
    mretIssueM = 0; sretIssueM = 0; wfiIssueM = 0;
  endtask

  task automatic expect_out(input string tag, input logic trap, input logic mret,
                            input logic sret, input logic [1:0] npriv, input logic [1:0] priv,
                            input logic [XLEN-1:0] cause, input logic stall);
    exp_t e;
    e.trap = trap; e.mret = mret; e.sret = sret; e.npriv = npriv;
    e.priv = priv; e.cause = cause; e.stall = stall;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Compare the oldest expectation at the negedge, then move to just after the next posedge.
  task automatic check_cycle();
    exp_t  e;
    string t;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (TrapM === e.trap) else begin
      fails++; $error("FAIL %s TrapM got %0b want %0b", t, TrapM, e.trap);
    end
    tests++;
    assert (mretM === e.mret) else begin
      fails++; $error("FAIL %s mretM got %0b want %0b", t, mretM, e.mret);
    end
    tests++;
    assert (sretM === e.sret) else begin
      fails++; $error("FAIL %s sretM got %0b want %0b", t, sretM, e.sret);
    end
    tests++;
    assert (NextPrivilegeModeM === e.npriv) else begin
      fails++; $error("FAIL %s NextPriv got %b want %b", t, NextPrivilegeModeM, e.npriv);
    end
    tests++;
    assert (PrivilegeModeW === e.priv) else begin
      fails++; $error("FAIL %s PrivW got %b want %b", t, PrivilegeModeW, e.priv);
    end
    tests++;
    assert (CauseM === e.cause) else begin
      fails++; $error("FAIL %s CauseM got %h want %h", t, CauseM, e.cause);
    end
    tests++;
    assert (WFIStallM === e.stall) else begin
      fails++; $error("FAIL %s WFIStallM got %0b want %0b", t, WFIStallM, e.stall);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; clr();
    MEDELEG_REGW = 0; MIDELEG_REGW = 0;
    STATUS_MPP = MM; STATUS_SPP = 0; STATUS_TSR = 0; STATUS_TW = 0;
    @(posedge clk); #1;
    expect_out("rst_init", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    reset_n = 1;

    // Reach S, then reset there for two cycles (wfi during reset must not start a wait).
    mretIssueM = 1; STATUS_MPP = SM;
    expect_out("mret_to_s", 0, 1, 0, SM, MM, 0, 0); check_cycle();
    clr(); reset_n = 0;
    expect_out("rst_in_s", 0, 0, 0, SM, SM, 0, 0); check_cycle();
    wfiIssueM = 1;
    expect_out("rst_hold", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    clr(); reset_n = 1;
    expect_out("post_rst", 0, 0, 0, MM, MM, 0, 0); check_cycle();

    // Exception delegation from U.
    mretIssueM = 1; STATUS_MPP = UM;
    expect_out("mret_to_u", 0, 1, 0, UM, MM, 0, 0); check_cycle();
    clr(); MEDELEG_REGW = 16'h0100; ExcValidM = 1; ExcCodeM = 4'd8;
    expect_out("exc8_deleg", 1, 0, 0, SM, UM, ecause(8), 0); check_cycle();
    clr(); sretIssueM = 1; STATUS_SPP = 0; STATUS_TSR = 0;
    expect_out("sret_to_u", 0, 0, 1, UM, SM, 0, 0); check_cycle();
    clr(); MEDELEG_REGW = 16'h0000; ExcValidM = 1; ExcCodeM = 4'd8;
    expect_out("exc8_nodeleg", 1, 0, 0, MM, UM, ecause(8), 0); check_cycle();

    // sret under TSR, then legal sret.
    clr(); mretIssueM = 1; STATUS_MPP = SM;
    expect_out("mret_to_s2", 0, 1, 0, SM, MM, 0, 0); check_cycle();
    clr(); MEDELEG_REGW = 16'h0004; STATUS_TSR = 1; sretIssueM = 1;
    expect_out("sret_tsr", 1, 0, 0, SM, SM, ecause(2), 0); check_cycle();
    STATUS_TSR = 0; STATUS_SPP = 0;
    expect_out("sret_legal", 0, 0, 1, UM, SM, 0, 0); check_cycle();
    clr(); MEDELEG_REGW = 16'h0800; ExcValidM = 1; ExcCodeM = 4'd11;
    expect_out("exc11_never_deleg", 1, 0, 0, MM, UM, ecause(11), 0); check_cycle();

    // WFI timeout from S with TW=1 (N=3: 7 stall cycles, then one trap cycle).
    clr(); MEDELEG_REGW = 0; mretIssueM = 1; STATUS_MPP = SM;
    expect_out("mret_to_s3", 0, 1, 0, SM, MM, 0, 0); check_cycle();
    clr(); STATUS_TW = 1; wfiIssueM = 1;
    expect_out("wfi_s_issue", 0, 0, 0, SM, SM, 0, 0); check_cycle();
    for (int i = 0; i < 7; i++) begin
      clr();
      if (i == 2) begin ExcValidM = 1; ExcCodeM = 4'd8; mretIssueM = 1; end
      expect_out("wfi_s_wait", 0, 0, 0, SM, SM, 0, 1); check_cycle();
    end
    clr();
    expect_out("wfi_timeout_trap", 1, 0, 0, MM, SM, ecause(2), 0); check_cycle();
    STATUS_TW = 0;
    expect_out("after_timeout", 0, 0, 0, MM, MM, 0, 0); check_cycle();

    // WFI in M woken by IntWakeM, then an interrupt trap.
    wfiIssueM = 1;
    expect_out("wfi_m_issue", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    clr();
    for (int i = 0; i < 3; i++) begin
      expect_out("wfi_m_wait", 0, 0, 0, MM, MM, 0, 1); check_cycle();
    end
    IntWakeM = 1;
    expect_out("wfi_wake", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    clr();
    expect_out("wake_idle", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    MIDELEG_REGW = 12'h080; IntValidM = 1; IntCodeM = 4'd7;
    expect_out("int7_m", 1, 0, 0, MM, MM, icause(7), 0); check_cycle();

    // Interrupt delegation from S, with MIDELEG bit 3 hardwired zero.
    clr(); mretIssueM = 1; STATUS_MPP = SM;
    expect_out("mret_to_s4", 0, 1, 0, SM, MM, 0, 0); check_cycle();
    clr(); MIDELEG_REGW = 12'hFFF; IntValidM = 1; IntCodeM = 4'd5;
    expect_out("int5_deleg", 1, 0, 0, SM, SM, icause(5), 0); check_cycle();
    IntCodeM = 4'd3;
    expect_out("int3_never_deleg", 1, 0, 0, MM, SM, icause(3), 0); check_cycle();

    // Priority and reset-in-WAIT.
    clr(); MIDELEG_REGW = 0; IntValidM = 1; IntCodeM = 4'd7; mretIssueM = 1; STATUS_MPP = UM;
    expect_out("int_beats_mret", 1, 0, 0, MM, MM, icause(7), 0); check_cycle();
    clr(); IntValidM = 1; IntCodeM = 4'd7; wfiIssueM = 1;
    expect_out("int_beats_wfi", 1, 0, 0, MM, MM, icause(7), 0); check_cycle();
    clr();
    expect_out("no_wait_entered", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    wfiIssueM = 1;
    expect_out("wfi_m_issue2", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    clr();
    expect_out("wfi_m_wait2", 0, 0, 0, MM, MM, 0, 1); check_cycle();
    reset_n = 0;
    expect_out("rst_in_wait", 0, 0, 0, MM, MM, 0, 0); check_cycle();
    reset_n = 1;
    expect_out("idle_after_rst", 0, 0, 0, MM, MM, 0, 0); check_cycle();

    // StallW holds the privilege register.
    StallW = 1; mretIssueM = 1; STATUS_MPP = SM;
    expect_out("mret_stalled", 0, 1, 0, SM, MM, 0, 0); check_cycle();
    clr();
    expect_out("priv_held", 0, 0, 0, MM, MM, 0, 0); check_cycle();

    // wfi in U is illegal.
    mretIssueM = 1; STATUS_MPP = UM;
    expect_out("mret_to_u2", 0, 1, 0, UM, MM, 0, 0); check_cycle();
    clr(); wfiIssueM = 1;
    expect_out("wfi_in_u", 1, 0, 0, MM, UM, ecause(2), 0); check_cycle();
    clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
